softmax_argmax_reader: RTL and testbench

//  Consumer end of the softmax output interface. Watches the softmax done/ack line and,
//  on each new ack, latches the packed FP32 probability vector. It then scans the vector

---
 rtl/softmax_argmax_reader.sv | 143 ++++++++++++++
 tb/tb_softmax_argmax_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/softmax_argmax_reader.sv
// Captures the softmax probability vector on each rising ack edge, then walks it one
// element per cycle using FP32 ordering and reports the winning class index and value.
module softmax_argmax_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH*NUM_CLASSES-1:0] vec_in,
  input  logic                              ack_in,
  output logic                              busy,
  output logic                              result_valid,
  output logic [IDX_WIDTH-1:0]              class_idx,
  output logic [DATA_WIDTH-1:0]             max_val
);

  localparam int EXP_W  = 8;
  localparam int MANT_W = DATA_WIDTH - EXP_W - 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state_reg, state_next;
  logic                    ack_prev_reg;
  logic                    busy_reg, busy_next;
  logic                    valid_reg, valid_next;
  logic [IDX_WIDTH-1:0]    class_idx_reg, class_idx_next;
  logic [DATA_WIDTH-1:0]   max_val_reg, max_val_next;
  logic [IDX_WIDTH-1:0]    idx_reg, idx_next;
  logic [DATA_WIDTH-1:0]   best_val_reg, best_val_next;
  logic [IDX_WIDTH-1:0]    best_idx_reg, best_idx_next;
  logic                    load_shadow;
  logic                    start;
  logic [DATA_WIDTH-1:0]   cand;
  logic                    cand_wins;

  logic [DATA_WIDTH-1:0]   elem_in    [NUM_CLASSES];
  logic [DATA_WIDTH-1:0]   shadow_reg [NUM_CLASSES];

  // Element 0 sits in the most significant slice of the packed vector.
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
    assign elem_in[gi] = vec_in[DATA_WIDTH*(NUM_CLASSES-gi)-1 -: DATA_WIDTH];
  end

  // True when a is strictly greater than b; a NaN never wins, any number beats a NaN.
  function automatic logic fp_greater(input logic [DATA_WIDTH-1:0] a,
                                      input logic [DATA_WIDTH-1:0] b);
    logic                  a_nan, b_nan, gt;
    logic [DATA_WIDTH-2:0] a_mag, b_mag;
    a_mag = a[DATA_WIDTH-2:0];
    b_mag = b[DATA_WIDTH-2:0];
    a_nan = (&a[DATA_WIDTH-2 -: EXP_W]) && (|a[MANT_W-1:0]);
    b_nan = (&b[DATA_WIDTH-2 -: EXP_W]) && (|b[MANT_W-1:0]);
    if (a_nan)                                  gt = 1'b0;
    else if (b_nan)                             gt = 1'b1;
    else if (a_mag == '0 && b_mag == '0)        gt = 1'b0;
    else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) gt = ~a[DATA_WIDTH-1];
    else if (!a[DATA_WIDTH-1])                  gt = (a_mag > b_mag);
    else                                        gt = (a_mag < b_mag);
    return gt;
  endfunction

  assign start     = ack_in & ~ack_prev_reg;
  assign cand      = shadow_reg[idx_reg];
  assign cand_wins = fp_greater(cand, best_val_reg);

  always_comb begin
    state_next     = state_reg;
    busy_next      = busy_reg;
    valid_next     = 1'b0;
    class_idx_next = class_idx_reg;
    max_val_next   = max_val_reg;
    idx_next       = idx_reg;
    best_val_next  = best_val_reg;
    best_idx_next  = best_idx_reg;
    load_shadow    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load_shadow   = 1'b1;
          best_val_next = elem_in[0];
          best_idx_next = '0;
          idx_next      = IDX_WIDTH'(1);
          busy_next     = 1'b1;
          state_next    = SCAN;
        end
      end
      SCAN: begin
        if (cand_wins) begin
          best_val_next = cand;
          best_idx_next = idx_reg;
        end
        if (idx_reg == LAST_IDX) begin
          class_idx_next = best_idx_next;
          max_val_next   = best_val_next;
          valid_next     = 1'b1;
          busy_next      = 1'b0;
          state_next     = DONE;
        end else begin
          idx_next = idx_reg + IDX_WIDTH'(1);
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ack_prev_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      class_idx_reg <= '0;
      max_val_reg   <= '0;
      idx_reg       <= '0;
      best_val_reg  <= '0;
      best_idx_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      ack_prev_reg  <= ack_in;
      busy_reg      <= busy_next;
      valid_reg     <= valid_next;
      class_idx_reg <= class_idx_next;
      max_val_reg   <= max_val_next;
      idx_reg       <= idx_next;
      best_val_reg  <= best_val_next;
      best_idx_reg  <= best_idx_next;
    end
  end

  // Shadow copy is pure datapath; it is only read while SCAN is active.
  always_ff @(posedge clk) begin
    if (load_shadow) shadow_reg <= elem_in;
  end

  assign busy         = busy_reg;
  assign result_valid = valid_reg;
  assign class_idx    = class_idx_reg;
  assign max_val      = max_val_reg;

endmodule

// File: tb/tb_softmax_argmax_reader.sv
// Bench for softmax_argmax_reader: vector table plus hand sequences, with a scoreboard
// queue filled at each start and drained by a monitor on every result_valid pulse.
module tb_softmax_argmax_reader;
  localparam int DW = 32;
  localparam int NC = 10;
  localparam int IW = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [DW*NC-1:0]   vec_in;
  logic               ack_in;
  logic               busy;
  logic               result_valid;
  logic [IW-1:0]      class_idx;
  logic [DW-1:0]      max_val;

  softmax_argmax_reader #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .vec_in(vec_in), .ack_in(ack_in),
    .busy(busy), .result_valid(result_valid), .class_idx(class_idx), .max_val(max_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW*NC-1:0] vec;
    logic [IW-1:0]    idx;
    logic [DW-1:0]    val;
  } vec_t;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] val;
    int            cyc;
  } exp_t;

  vec_t tbl [7];
  exp_t sb [$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rising ack at the next edge; the result must appear NC edges after this point.
  task automatic start_scan(input logic [DW*NC-1:0] v, input logic [IW-1:0] i,
                            input logic [DW-1:0] val);
    exp_t e;
    vec_in = v;
    ack_in = 1'b0;
    tick();
    ack_in = 1'b1;
    e.idx = i;
    e.val = val;
    e.cyc = cyc + NC;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: %0d results still pending after %0d cycles", sb.size(), budget);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      pulse_cnt++;
      $display("result cycle=%0d class_idx=%0d max_val=%08h", cyc, class_idx, max_val);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got valid with class_idx=%0d expected none", class_idx);
      end else begin
        mon_e = sb.pop_front();
        chk("class_idx", 64'(class_idx), 64'(mon_e.idx));
        chk("max_val", 64'(max_val), 64'(mon_e.val));
        chk("latency_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    // 0: softmax-like vector, 0.5687 at class 6 (other words are smaller positives)
    tbl[0].vec = {32'h3D05879C, 32'h3CB295EA, 32'h3DB53F7D, 32'h3DC84B5E, 32'h3C30F27C,
                  32'h3D130BE1, 32'h3F119653, 32'h3CD5CFAB, 32'h3DA57A78, 32'h3D16BB99};
    tbl[0].idx = 4'd6;  tbl[0].val = 32'h3F119653;
    // 1: all equal -> lowest index
    tbl[1].vec = {10{32'h3DCCCCCD}};
    tbl[1].idx = 4'd0;  tbl[1].val = 32'h3DCCCCCD;
    // 2: negatives, smallest magnitude wins
    tbl[2].vec = {{3{32'hC0400000}}, 32'hBF800000, {3{32'hC0400000}}, 32'hC0000000,
                  {2{32'hC0400000}}};
    tbl[2].idx = 4'd3;  tbl[2].val = 32'hBF800000;
    // 3: NaN at 0 is displaced by -0 at 1; +0 at 5 only ties with -0
    tbl[3].vec = {32'h7FC00000, {4{32'h80000000}}, 32'h00000000, {4{32'h80000000}}};
    tbl[3].idx = 4'd1;  tbl[3].val = 32'h80000000;
    // 4: all NaN -> index 0 keeps its NaN
    tbl[4].vec = {32'h7FC00001, {9{32'hFFC00000}}};
    tbl[4].idx = 4'd0;  tbl[4].val = 32'h7FC00001;
    // 5: -Inf at 2, +Inf at 4, rest 1.0
    tbl[5].vec = {{2{32'h3F800000}}, 32'hFF800000, 32'h3F800000, 32'h7F800000,
                  {5{32'h3F800000}}};
    tbl[5].idx = 4'd4;  tbl[5].val = 32'h7F800000;
    // 6: tiny positive denormal beats every negative
    tbl[6].vec = {32'hC0A00000, {7{32'hBF800000}}, 32'h00000001, 32'hBF800000};
    tbl[6].idx = 4'd8;  tbl[6].val = 32'h00000001;

    reset = 1'b1;
    ack_in = 1'b0;
    vec_in = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(result_valid), 64'd0);
    chk("reset_class_idx", 64'(class_idx), 64'd0);
    chk("reset_max_val", 64'(max_val), 64'd0);

    // Table: after capture, scramble vec_in to confirm it is no longer observed.
    for (int t = 0; t < 7; t++) begin
      start_scan(tbl[t].vec, tbl[t].idx, tbl[t].val);
      tick();
      chk("busy_in_scan", 64'(busy), 64'd1);
      for (int w = 0; w < NC; w++) vec_in[w*DW +: DW] = $urandom;
      wait_empty(30);
      tick();
    end

    // Held ack: one pulse only, then a fresh edge with class 9 largest.
    base = pulse_cnt;
    start_scan(tbl[1].vec, 4'd0, 32'h3DCCCCCD);
    repeat (40) tick();
    chk("held_ack_pulses", 64'(pulse_cnt - base), 64'd1);
    begin
      logic [DW*NC-1:0] v9;
      v9 = tbl[0].vec;
      v9[DW-1:0] = 32'h3F800000;
      start_scan(v9, 4'd9, 32'h3F800000);
    end
    wait_empty(30);

    // Rising ack in the middle of a scan is ignored.
    base = pulse_cnt;
    start_scan(tbl[2].vec, 4'd3, 32'hBF800000);
    repeat (3) tick();
    ack_in = 1'b0;
    tick();
    ack_in = 1'b1;
    repeat (25) tick();
    chk("midscan_ack_pulses", 64'(pulse_cnt - base), 64'd1);

    // Reset four cycles into a scan aborts it.
    base = pulse_cnt;
    vec_in = tbl[0].vec;
    ack_in = 1'b0;
    tick();
    ack_in = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    ack_in = 1'b0;
    tick();
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_class_idx", 64'(class_idx), 64'd0);
    chk("abort_max_val", 64'(max_val), 64'd0);
    repeat (15) tick();
    chk("abort_pulses", 64'(pulse_cnt - base), 64'd0);
    start_scan(tbl[0].vec, 4'd6, 32'h3F119653);
    wait_empty(30);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
